ram_sp_arbiter: RTL and testbench

//  Shares one synchronous single-port RAM (cs/we/oe, bidirectional data bus) among N_REQ

---
 rtl/ram_ctrl_pkg.sv | 20 ++
 rtl/ram_sp_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/ram_sp_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_sp_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the single-port RAM controller: access-sequencer state
// encoding and the default word/address widths of the attached RAM instance.
package ram_ctrl_pkg;

  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD1  = 2'd2,
    ST_RD2  = 2'd3
  } ram_state_t;

  // RD1 is the only state in which the RAM cannot take a new access next cycle.
  function automatic logic state_can_grant(input ram_state_t s);
    return (s != ST_RD1);
  endfunction

endpackage

// File: rtl/ram_sp_arbiter_if.sv
// Requester-side handshake bundle of the shared RAM arbiter: packed per-requester
// request fields in, one-hot grant / read-valid pulses and shared read word out.
interface ram_sp_arbiter_if
  import ram_ctrl_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
);

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            req_we;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            rd_valid;
  logic [DATA_WIDTH-1:0]       rd_data;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rd_valid, rd_data
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rd_valid, rd_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping
// to the lowest asserted request when nothing at or above ptr is pending.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [N-1:0] upper_req;
  logic [N-1:0] pick_src;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign upper_req[gi] = req[gi] && (PW'(gi) >= ptr);
    end
  endgenerate

  assign pick_src = (|upper_req) ? upper_req : req;
  // Isolate the lowest set bit of the chosen request vector.
  assign grant    = pick_src & (~pick_src + N'(1));
  assign valid    = |req;

endmodule

// File: rtl/ram_sp_arbiter.sv
// Shares one synchronous single-port RAM among N_REQ requesters: round-robin grant,
// registered RAM pin sequencing (WR / RD1 / RD2) and the write-side bus driver.
module ram_sp_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_sp_arbiter_if.slave       bus,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  localparam int PW = $clog2(N_REQ);

  ram_state_t            state_reg, state_next;
  logic [PW-1:0]         ptr_reg, ptr_next;
  logic [PW-1:0]         owner_reg, owner_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [N_REQ-1:0]      rd_valid_reg, rd_valid_next;
  logic [DATA_WIDTH-1:0] rd_data_reg, rd_data_next;
  logic                  ram_cs_reg, ram_we_reg, ram_oe_reg;

  logic [ADDR_WIDTH-1:0] req_addr_arr  [N_REQ];
  logic [DATA_WIDTH-1:0] req_wdata_arr [N_REQ];

  logic [N_REQ-1:0]      arb_grant;
  logic                  arb_valid;
  logic                  grant_en;
  logic [PW-1:0]         win_idx;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // Reset masks the grant so no request is accepted while the sequencer is held.
  assign grant_en = arb_valid && state_can_grant(state_reg) && !rst;
  assign bus.gnt  = grant_en ? arb_grant : '0;

  always_comb begin
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        win_idx   = PW'(i);
        win_we    = bus.req_we[i];
        win_addr  = req_addr_arr[i];
        win_wdata = req_wdata_arr[i];
      end
    end
  end

  always_comb begin
    state_next    = ST_IDLE;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rd_valid_next = '0;
    rd_data_next  = rd_data_reg;

    case (state_reg)
      ST_RD1: state_next = ST_RD2;
      ST_RD2: begin
        rd_data_next  = ram_data;
        rd_valid_next = N_REQ'(1) << owner_reg;
      end
      default: ;
    endcase

    // A grant in WR or RD2 chains straight into the next access with no bubble.
    if (grant_en) begin
      state_next = win_we ? ST_WR : ST_RD1;
      ptr_next   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
      owner_next = win_idx;
      addr_next  = win_addr;
      wdata_next = win_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rd_valid_reg <= '0;
      rd_data_reg  <= '0;
      ram_cs_reg   <= 1'b0;
      ram_we_reg   <= 1'b0;
      ram_oe_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rd_valid_reg <= rd_valid_next;
      rd_data_reg  <= rd_data_next;
      ram_cs_reg   <= (state_next != ST_IDLE);
      ram_we_reg   <= (state_next == ST_WR);
      ram_oe_reg   <= (state_next == ST_RD1) || (state_next == ST_RD2);
    end
  end

  assign ram_cs       = ram_cs_reg;
  assign ram_we       = ram_we_reg;
  assign ram_oe       = ram_oe_reg;
  assign ram_addr     = addr_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_data  = rd_data_reg;

  // Only WR owns the bus; the RAM drives it only while oe is high, which never overlaps WR.
  assign ram_data = (state_reg == ST_WR) ? wdata_reg : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter: behavioural sync RAM with preload, reference memory and
// round-robin model, scoreboard queues checked by a negedge monitor.
module tb_ram_sp_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_sp_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  ram_sp_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

  // Synchronous single-port RAM; a write edge coinciding with reset is suppressed.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ram_q;
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_cs && ram_we && !rst) mem[ram_addr] <= ram_data;
    if (ram_cs && !ram_we) ram_q <= mem[ram_addr];
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : {DW{1'bz}};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_data_q [N][$];
  int            exp_cyc_q  [N][$];
  int            last_k  = N - 1;
  bit            rd1_blk = 1'b0;
  bit            pw_valid = 1'b0;
  logic [AW-1:0] pw_addr;
  logic [DW-1:0] pw_data;
  int            cyc = 0;
  logic [N-1:0]  gnt_last = '0;
  logic [N-1:0]  rdv_last = '0;
  logic [DW-1:0] rdd_last = '0;
  int            log_k [$];
  int            log_c [$];

  always @(negedge clk) begin : monitor
    int            exp_k;
    logic [N-1:0]  exp_g;
    logic [DW-1:0] d;
    int            c;
    cyc++;
    if (pre_en) ref_mem[pre_addr] = pre_data;

    check("bus_contention", {31'd0, ram_we && ram_oe}, 32'd0);

    if (pw_valid) begin
      check("wr_pins", {29'd0, ram_cs, ram_we, ram_oe}, 32'b110);
      check("wr_addr", {24'd0, ram_addr}, {24'd0, pw_addr});
      check("wr_bus",  {24'd0, ram_data}, {24'd0, pw_data});
      if (!rst) ref_mem[pw_addr] = pw_data;
      pw_valid = 1'b0;
    end

    check("rd_valid_onehot", {31'd0, $countones(bus.rd_valid) <= 1}, 32'd1);
    for (int i = 0; i < N; i++) begin
      if (bus.rd_valid[i]) begin
        if (exp_data_q[i].size() == 0) begin
          n_checks++;
          $display("FAIL rd_valid_unexpected: requester %0d got rd_valid, required none", i);
        end else begin
          d = exp_data_q[i].pop_front();
          c = exp_cyc_q[i].pop_front();
          check("rd_data", {24'd0, bus.rd_data}, {24'd0, d});
          check("rd_latency", cyc - c, 32'd3);
        end
      end
    end

    if (rst) begin
      check("gnt_in_reset", {28'd0, bus.gnt}, 32'd0);
      for (int i = 0; i < N; i++) begin
        exp_data_q[i].delete();
        exp_cyc_q[i].delete();
      end
      last_k  = N - 1;
      rd1_blk = 1'b0;
    end else begin
      exp_k = -1;
      if (!rd1_blk) begin
        for (int j = 1; j <= N; j++)
          if (exp_k < 0 && bus.req[(last_k + j) % N]) exp_k = (last_k + j) % N;
      end
      exp_g = (exp_k < 0) ? '0 : (N'(1) << exp_k);
      check("gnt", {28'd0, bus.gnt}, {28'd0, exp_g});
      rd1_blk = 1'b0;
      if (exp_k >= 0) begin
        last_k = exp_k;
        log_k.push_back(exp_k);
        log_c.push_back(cyc);
        if (bus.req_we[exp_k]) begin
          pw_valid = 1'b1;
          pw_addr  = bus.req_addr[exp_k*AW +: AW];
          pw_data  = bus.req_wdata[exp_k*DW +: DW];
        end else begin
          exp_data_q[exp_k].push_back(ref_mem[bus.req_addr[exp_k*AW +: AW]]);
          exp_cyc_q[exp_k].push_back(cyc);
          rd1_blk = 1'b1;
        end
      end
    end

    gnt_last = bus.gnt;
    rdv_last = bus.rd_valid;
    rdd_last = bus.rd_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic raise(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]               = 1'b1;
    bus.req_we[i]            = we;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_gnt(input int i);
    int t = 0;
    do begin
      tick();
      t++;
    end while (!gnt_last[i] && t < 40);
    if (!gnt_last[i]) begin
      n_checks++;
      $display("FAIL gnt_timeout: requester %0d got no gnt, required one within 40 cycles", i);
    end
    bus.req[i] = 1'b0;
  endtask

  task automatic wait_rd(input int i, input logic [DW-1:0] exp, input string name);
    int t = 0;
    do begin
      tick();
      t++;
    end while (!rdv_last[i] && t < 10);
    if (rdv_last[i]) check(name, {24'd0, rdd_last}, {24'd0, exp});
    else begin
      n_checks++;
      $display("FAIL %s: requester %0d got no rd_valid, required one within 10 cycles", name, i);
    end
  endtask

  task automatic run_until(input int n, input bit hold);
    int t = 0;
    while (log_k.size() < n && t < 40) begin
      tick();
      t++;
      if (!hold) for (int i = 0; i < N; i++) if (gnt_last[i]) bus.req[i] = 1'b0;
    end
    if (log_k.size() < n) begin
      n_checks++;
      $display("FAIL grant_count_timeout: got %0d grants, required %0d", log_k.size(), n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit dropped;
    rst           = 1'b1;
    pre_en        = 1'b0;
    pre_addr      = '0;
    pre_data      = '0;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    tick();

    // Preload under reset: all locations zero except a few read targets.
    for (int a = 0; a < 256; a++) begin
      pre_en   = 1'b1;
      pre_addr = AW'(a);
      pre_data = (a >= 8'h40 && a < 8'h44) ? DW'(8'h90 + a) : '0;
      tick();
    end
    pre_en = 1'b0;
    tick();

    check("rst_pins", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    check("rst_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    check("rst_rd_valid", {28'd0, bus.rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Single write then read
    raise(0, 1'b1, 8'h10, 8'hA5);
    wait_gnt(0);
    raise(0, 1'b0, 8'h10, 8'h00);
    wait_gnt(0);
    wait_rd(0, 8'hA5, "wr_then_rd");
    repeat (3) tick();

    // Fairness: all four reads held
    do_reset();
    log_k.delete();
    log_c.delete();
    for (int i = 0; i < N; i++) raise(i, 1'b0, AW'(8'h40 + i), 8'h00);
    run_until(5, 1'b1);
    bus.req = '0;
    for (int g = 0; g < 5 && g < log_k.size(); g++) check("rr_order", log_k[g], g % N);
    repeat (6) tick();

    // Back-to-back write then queued read of the same word
    do_reset();
    log_k.delete();
    log_c.delete();
    raise(1, 1'b1, 8'h01, 8'h3C);
    raise(2, 1'b0, 8'h01, 8'h00);
    run_until(2, 1'b0);
    if (log_k.size() >= 2) begin
      check("b2b_first", log_k[0], 1);
      check("b2b_second", log_k[1], 2);
      check("b2b_gap", log_c[1] - log_c[0], 1);
    end
    wait_rd(2, 8'h3C, "b2b_rd_data");
    repeat (3) tick();

    // Reset during RD1
    raise(1, 1'b0, 8'h05, 8'h00);
    wait_gnt(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rd_pins", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    check("rst_rd_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_rd_gnt", {28'd0, bus.gnt}, 32'd0);
    check("rst_rd_rd_valid", {28'd0, bus.rd_valid}, 32'd0);
    check("rst_rd_rd_data", {24'd0, bus.rd_data}, 32'd0);
    repeat (6) tick();
    log_k.delete();
    log_c.delete();
    raise(1, 1'b0, 8'h41, 8'h00);
    raise(3, 1'b0, 8'h43, 8'h00);
    run_until(2, 1'b0);
    if (log_k.size() >= 1) check("ptr_after_reset", log_k[0], 1);
    repeat (6) tick();

    // Reset during WR: old value must survive
    raise(0, 1'b1, 8'h20, 8'hFF);
    wait_gnt(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    raise(0, 1'b0, 8'h20, 8'h00);
    wait_gnt(0);
    wait_rd(0, 8'h00, "rd_after_aborted_write");
    repeat (3) tick();

    // Random mixes against the reference model
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        dropped = 1'b0;
        if (bus.req[i] && gnt_last[i]) bus.req[i] = 1'b0;
        else if (bus.req[i] && $urandom_range(0, 63) == 0) begin
          bus.req[i] = 1'b0;
          dropped    = 1'b1;
        end
        if (!bus.req[i] && !dropped && $urandom_range(0, 2) == 0)
          raise(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
      end
      tick();
    end
    for (int i = 0; i < N; i++) if (bus.req[i] && gnt_last[i]) bus.req[i] = 1'b0;
    tick();
    bus.req = '0;
    repeat (10) tick();

    for (int i = 0; i < N; i++) check("rd_outstanding", exp_data_q[i].size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
